seg_capture_encoder: RTL and testbench

//  Inverse of the team's BCD-to-7-segment decoder: snoops a multiplexed, active-low 7-seg bus
//  (segments + digit strobes), waits for each digit's glyph to be stable, maps glyph back to BCD.

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_glyph_encoder.sv | 38 +++
 rtl/seg_capture_encoder.sv | 137 +++++++++++++
 tb/tb_seg_capture_encoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared glyph constants, decoded-glyph payload and FSM state type for the 7-seg capture path.
package seg_pkg;

    // Active-low segment patterns, bit6=a ... bit0=g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001101;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ERR_NIBBLE = 4'hF;

    typedef struct packed {
        logic       err;
        logic [3:0] nibble;
    } glyph_code_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_FULL    = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/seg_glyph_encoder.sv
// Combinational 7-seg glyph -> {err, nibble}; hex letters accepted only when SEG_HEX_EN is defined.
module seg_glyph_encoder
    import seg_pkg::*;
(
    input  logic [6:0]  glyph,
    output glyph_code_t code_c
);

    always_comb begin
        code_c.err    = 1'b0;
        code_c.nibble = 4'h0;
        case (glyph)
            SEG_0:   code_c.nibble = 4'h0;
            SEG_1:   code_c.nibble = 4'h1;
            SEG_2:   code_c.nibble = 4'h2;
            SEG_3:   code_c.nibble = 4'h3;
            SEG_4:   code_c.nibble = 4'h4;
            SEG_5:   code_c.nibble = 4'h5;
            SEG_6:   code_c.nibble = 4'h6;
            SEG_7:   code_c.nibble = 4'h7;
            SEG_8:   code_c.nibble = 4'h8;
            SEG_9:   code_c.nibble = 4'h9;
`ifdef SEG_HEX_EN
            SEG_A:   code_c.nibble = 4'hA;
            SEG_B:   code_c.nibble = 4'hB;
            SEG_C:   code_c.nibble = 4'hC;
            SEG_D:   code_c.nibble = 4'hD;
            SEG_E:   code_c.nibble = 4'hE;
            SEG_F:   code_c.nibble = 4'hF;
`endif
            default: begin
                code_c.err    = 1'b1;
                code_c.nibble = ERR_NIBBLE;
            end
        endcase
    end

endmodule

// File: rtl/seg_capture_encoder.sv
// Snoops a multiplexed active-low 7-seg bus, commits stable glyphs as BCD and emits full frames
// over valid/ready. Hex glyph support is enabled by defining SEG_HEX_EN.
module seg_capture_encoder
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    overrun
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_PRE = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0]   sel_c;
    logic                    sel_ok_c;
    logic                    same_c;
    logic                    commit_c;
    logic                    load_c;
    logic [IDX_W-1:0]        idx_c;
    logic [IDX_W-1:0]        last_idx;
    logic [6:0]              last_seg;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next_c;
    logic [NUM_DIGITS-1:0]   seen;
    logic [NUM_DIGITS-1:0]   seen_next_c;
    logic [NUM_DIGITS-1:0]   commit_mask_c;
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [NUM_DIGITS-1:0]   shadow_err;
    logic                    stalled;
    state_t                  state;
    glyph_code_t             code_c;

    seg_glyph_encoder u_glyph_encoder (
        .glyph  (seg),
        .code_c (code_c)
    );

    // Strobe decode, stability counting and commit/load decisions
    always_comb begin
        sel_c    = ~dig_sel;
        sel_ok_c = (sel_c != '0) && ((sel_c & (sel_c - DIG_ONE)) == '0);
        idx_c    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel_c[i]) idx_c = IDX_W'(i);
        end
        same_c = sel_ok_c && (idx_c == last_idx) && (seg == last_seg);

        cnt_next_c = '0;
        if (same_c) begin
            cnt_next_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        end else if (sel_ok_c) begin
            cnt_next_c = CNT_ONE;
        end

        commit_c      = same_c && (cnt == CNT_PRE);
        commit_mask_c = commit_c ? (DIG_ONE << idx_c) : '0;
        load_c        = (state == ST_FULL) && (!out_valid || out_ready);
        seen_next_c   = (load_c ? '0 : seen) | commit_mask_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_idx <= '0;
            last_seg <= '0;
            cnt      <= '0;
        end else begin
            last_idx <= idx_c;
            last_seg <= seg;
            cnt      <= cnt_next_c;
        end
    end

    // Shadow frame, frame FSM and registered output port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_bcd <= '0;
            shadow_err <= '0;
            seen       <= '0;
            state      <= ST_COLLECT;
            stalled    <= 1'b0;
            out_valid  <= 1'b0;
            out_bcd    <= '0;
            out_err    <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            seen    <= seen_next_c;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (commit_mask_c[i]) begin
                    shadow_bcd[4*i +: 4] <= code_c.nibble;
                    shadow_err[i]        <= code_c.err;
                end
            end

            case (state)
                ST_COLLECT: begin
                    if (seen == '1)                  state <= ST_FULL;
                    else if (out_valid && !out_ready) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (seen == '1)     state <= ST_FULL;
                    else if (out_ready) state <= ST_COLLECT;
                end
                ST_FULL: begin
                    if (load_c) begin
                        out_bcd <= shadow_bcd;
                        out_err <= shadow_err;
                        stalled <= 1'b0;
                        state   <= ST_COLLECT;
                    end else begin
                        // Pulse once per blocked frame, not every stalled cycle
                        overrun <= !stalled;
                        stalled <= 1'b1;
                    end
                end
                default: state <= ST_COLLECT;
            endcase

            if (load_c)                      out_valid <= 1'b1;
            else if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_capture_encoder.sv
// Directed bench for seg_capture_encoder: table of frames plus hand-written stall/reset/stability sequences.
module tb_seg_capture_encoder;
    import seg_pkg::*;

    logic        clk;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [3:0]  out_err;
    logic        overrun;

    int passed;
    int total;

    seg_capture_encoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [3:0][6:0]  glyph;
        logic [15:0]      bcd;
        logic [3:0]       err;
    } frame_vec_t;

    frame_vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic hold(input int i, input logic [6:0] g, input int n);
        dig_sel = ~(4'b0001 << i);
        seg     = g;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        dig_sel = 4'b1111;
        seg     = SEG_BLANK;
        repeat (n) @(negedge clk);
    endtask

    // Called right after the last digit's committing edge, with out_ready=1
    task automatic finish_frame(input string name, input logic [15:0] bcd, input logic [3:0] err);
        idle(1);
        check({name, "_valid_e1"}, 32'(out_valid), 32'd0);
        idle(1);
        check({name, "_valid_e2"}, 32'(out_valid), 32'd1);
        check({name, "_bcd"}, 32'(out_bcd), 32'(bcd));
        check({name, "_err"}, 32'(out_err), 32'(err));
        idle(1);
        check({name, "_accepted"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        dig_sel   = 4'b1111;
        seg       = SEG_BLANK;
        out_ready = 1'b1;

        vecs[0] = '{"f2345", {SEG_5, SEG_4, SEG_3, SEG_2}, 16'h5432, 4'b0000};
        vecs[1] = '{"f0189", {SEG_9, SEG_8, SEG_1, SEG_0}, 16'h9810, 4'b0000};
        vecs[2] = '{"fblank", {SEG_0, SEG_BLANK, SEG_7, SEG_6}, 16'h0F76, 4'b0100};
`ifdef SEG_HEX_EN
        vecs[3] = '{"fhexA", {SEG_3, SEG_2, SEG_1, SEG_A}, 16'h321A, 4'b0000};
`else
        vecs[3] = '{"fhexA", {SEG_3, SEG_2, SEG_1, SEG_A}, 16'h321F, 4'b0001};
`endif
        vecs[4] = '{"fbad", {7'b1010101, SEG_8, SEG_8, SEG_8}, 16'hF888, 4'b1000};

        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(out_bcd), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            for (int d = 0; d < 4; d++) hold(d, vecs[v].glyph[d], 4);
            finish_frame(vecs[v].name, vecs[v].bcd, vecs[v].err);
        end

        // Short runs and multi-low strobes never commit; a re-commit keeps the latest glyph
        hold(1, SEG_9, 4);
        hold(1, SEG_1, 4);
        hold(0, SEG_5, 3);
        hold(0, SEG_6, 3);
        dig_sel = 4'b1100;
        seg     = SEG_6;
        repeat (5) @(negedge clk);
        hold(2, SEG_2, 4);
        hold(3, SEG_3, 4);
        idle(4);
        check("nocommit_valid", 32'(out_valid), 32'd0);
        hold(0, SEG_4, 4);
        finish_frame("recommit", 16'h3214, 4'b0000);

        // Consumer stalls: second frame completes while first pending
        out_ready = 1'b0;
        hold(0, SEG_2, 4); hold(1, SEG_3, 4); hold(2, SEG_4, 4); hold(3, SEG_5, 4);
        idle(2);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_bcd", 32'(out_bcd), 32'h5432);
        hold(0, SEG_9, 4); hold(1, SEG_8, 4); hold(2, SEG_7, 4); hold(3, SEG_6, 4);
        idle(1);
        check("ovr_e1", 32'(overrun), 32'd0);
        idle(1);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_bcd_held", 32'(out_bcd), 32'h5432);
        idle(1);
        check("ovr_once", 32'(overrun), 32'd0);
        check("ovr_valid_held", 32'(out_valid), 32'd1);
        check("ovr_bcd_held2", 32'(out_bcd), 32'h5432);
        out_ready = 1'b1;
        idle(1);
        check("release_valid", 32'(out_valid), 32'd1);
        check("release_bcd", 32'(out_bcd), 32'h6789);
        idle(1);
        check("release_accept", 32'(out_valid), 32'd0);

        // Reset mid-frame clears outputs immediately and discards the partial frame
        out_ready = 1'b0;
        hold(0, SEG_1, 4); hold(1, SEG_1, 4); hold(2, SEG_1, 4); hold(3, SEG_1, 4);
        idle(2);
        check("pre_rst_bcd", 32'(out_bcd), 32'h1111);
        hold(0, SEG_7, 4); hold(1, SEG_7, 4); hold(2, SEG_7, 4); hold(3, SEG_7, 2);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_bcd", 32'(out_bcd), 32'd0);
        check("midrst_err", 32'(out_err), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        hold(3, SEG_7, 4);
        idle(6);
        check("no_late_load_valid", 32'(out_valid), 32'd0);
        check("no_late_load_bcd", 32'(out_bcd), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
